// File: rtl/l2_mem_responder_pkg.sv
// Shared NoC constants, header layout and FSM encoding for the L2 memory responder.
// The NoC packet checkers reuse these definitions.
package l2_mem_responder_pkg;

    localparam int unsigned FLIT_W         = 64;
    localparam int unsigned ADDR_W         = 40;
    localparam int unsigned WORDS_PER_LINE = 8;
    localparam int unsigned WORD_IDX_W     = 3;
    localparam int unsigned LINE_OFFSET_W  = 6;

    localparam int unsigned CHIPID_LSB   = 50, CHIPID_W   = 14;
    localparam int unsigned X_LSB        = 42, X_W        = 8;
    localparam int unsigned Y_LSB        = 34, Y_W        = 8;
    localparam int unsigned FBITS_LSB    = 30, FBITS_W    = 4;
    localparam int unsigned PLEN_LSB     = 22, PLEN_W     = 8;
    localparam int unsigned MSG_TYPE_LSB = 14, MSG_TYPE_W = 8;
    localparam int unsigned MSHR_LSB     = 6,  MSHR_W     = 8;
    localparam int unsigned OPTIONS_LSB  = 0,  OPTIONS_W  = 6;

    localparam logic [MSG_TYPE_W-1:0] MSG_LOAD_MEM      = 8'd19;
    localparam logic [MSG_TYPE_W-1:0] MSG_STORE_MEM     = 8'd20;
    localparam logic [MSG_TYPE_W-1:0] MSG_LOAD_MEM_ACK  = 8'd24;
    localparam logic [MSG_TYPE_W-1:0] MSG_STORE_MEM_ACK = 8'd25;

    typedef struct packed {
        logic [CHIPID_W-1:0]   chipid;
        logic [X_W-1:0]        x;
        logic [Y_W-1:0]        y;
        logic [FBITS_W-1:0]    fbits;
        logic [PLEN_W-1:0]     payload_len;
        logic [MSG_TYPE_W-1:0] msg_type;
        logic [MSHR_W-1:0]     mshr;
        logic [OPTIONS_W-1:0]  options;
    } noc_hdr_t;

    typedef enum logic [2:0] {
        ST_RX_HDR  = 3'd0,
        ST_RX_ADDR = 3'd1,
        ST_RX_SRC  = 3'd2,
        ST_RX_DATA = 3'd3,
        ST_WAIT    = 3'd4,
        ST_TX_HDR  = 3'd5,
        ST_TX_DATA = 3'd6,
        ST_DRAIN   = 3'd7
    } state_e;

    function automatic logic is_supported(input logic [MSG_TYPE_W-1:0] t);
        return (t == MSG_LOAD_MEM) || (t == MSG_STORE_MEM);
    endfunction

    // Response header: routed back to the request source, fbits/options cleared.
    function automatic noc_hdr_t make_resp_hdr(
        input logic [CHIPID_W-1:0]   chipid,
        input logic [X_W-1:0]        x,
        input logic [Y_W-1:0]        y,
        input logic [MSG_TYPE_W-1:0] req_type,
        input logic [MSHR_W-1:0]     mshr
    );
        noc_hdr_t h;
        h        = '0;
        h.chipid = chipid;
        h.x      = x;
        h.y      = y;
        h.mshr   = mshr;
        if (req_type == MSG_LOAD_MEM) begin
            h.msg_type    = MSG_LOAD_MEM_ACK;
            h.payload_len = PLEN_W'(WORDS_PER_LINE);
        end else begin
            h.msg_type    = MSG_STORE_MEM_ACK;
        end
        return h;
    endfunction

endpackage

// File: rtl/l2_mem_responder_if.sv
// NoC2 request / NoC3 response channel pair between the L2 and the memory responder.
interface l2_mem_responder_if;
    import l2_mem_responder_pkg::*;

    logic              noc2_valid_in;
    logic [FLIT_W-1:0] noc2_data_in;
    logic              noc2_ready_out;
    logic              noc3_valid_out;
    logic [FLIT_W-1:0] noc3_data_out;
    logic              noc3_ready_in;

    modport master (
        output noc2_valid_in, noc2_data_in, noc3_ready_in,
        input  noc2_ready_out, noc3_valid_out, noc3_data_out
    );

    modport slave (
        input  noc2_valid_in, noc2_data_in, noc3_ready_in,
        output noc2_ready_out, noc3_valid_out, noc3_data_out
    );
endinterface

// File: rtl/l2_mem_store.sv
// Line-granular backing store: LINES x 8 x 64-bit registers, one write port,
// one combinational read port, cleared by async reset.
module l2_mem_store
    import l2_mem_responder_pkg::*;
#(
    parameter int unsigned LINES  = 4,
    parameter int unsigned LINE_W = $clog2(LINES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [LINE_W-1:0]     wr_line,
    input  logic [WORD_IDX_W-1:0] wr_word,
    input  logic [FLIT_W-1:0]     wr_data,
    input  logic [LINE_W-1:0]     rd_line,
    input  logic [WORD_IDX_W-1:0] rd_word,
    output logic [FLIT_W-1:0]     rd_data
);
    logic [FLIT_W-1:0] mem_q [LINES][WORDS_PER_LINE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < int'(LINES); l++) begin
                for (int w = 0; w < int'(WORDS_PER_LINE); w++) begin
                    mem_q[l][w] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[wr_line][wr_word] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_line][rd_word];

endmodule

// File: rtl/l2_mem_responder.sv
// Memory-side NoC endpoint: serves LOAD_MEM / STORE_MEM from a small backing store
// and answers with LOAD_MEM_ACK / STORE_MEM_ACK after MEM_LAT cycles.
module l2_mem_responder
    import l2_mem_responder_pkg::*;
#(
    parameter int unsigned LINES   = 4,
    parameter int unsigned MEM_LAT = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    l2_mem_responder_if.slave noc,
    output logic              busy,
    output logic              err_unsupported
);
    localparam int unsigned LINE_W = $clog2(LINES);
    localparam int unsigned LAT_W  = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    state_e                  state_q, state_d;
    logic [MSG_TYPE_W-1:0]   msg_q, msg_d;
    logic [MSHR_W-1:0]       mshr_q, mshr_d;
    logic [PLEN_W-1:0]       plen_q, plen_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [CHIPID_W-1:0]     chip_q, chip_d;
    logic [X_W-1:0]          x_q, x_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic [PLEN_W-1:0]       flit_q, flit_d;
    logic [WORD_IDX_W-1:0]   word_q, word_d;
    logic                    wfull_q, wfull_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic                    ready_q, ready_d;
    logic                    valid3_q, valid3_d;
    logic [FLIT_W-1:0]       data3_q, data3_d;
    logic                    busy_q, busy_d;
    logic                    err_q, err_d;

    logic                    hs2_c, hs3_c, last_flit_c;
    logic                    wr_en_c;
    logic [WORD_IDX_W-1:0]   rd_word_c;
    logic [FLIT_W-1:0]       rd_data_c;

    assign hs2_c       = noc.noc2_valid_in && ready_q;
    assign hs3_c       = valid3_q && noc.noc3_ready_in;
    // Payload flits are numbered from 1 after the header; this one is the last.
    assign last_flit_c = ({1'b0, flit_q} + 9'd1) == {1'b0, plen_q};
    assign rd_word_c   = (state_q == ST_TX_DATA) ? word_q + 3'd1 : '0;

    l2_mem_store #(.LINES(LINES), .LINE_W(LINE_W)) u_store (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_c),
        .wr_line (line_q),
        .wr_word (word_q),
        .wr_data (noc.noc2_data_in),
        .rd_line (line_q),
        .rd_word (rd_word_c),
        .rd_data (rd_data_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RX_HDR;
            msg_q    <= '0;
            mshr_q   <= '0;
            plen_q   <= '0;
            line_q   <= '0;
            chip_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            flit_q   <= '0;
            word_q   <= '0;
            wfull_q  <= 1'b0;
            lat_q    <= '0;
            ready_q  <= 1'b1;
            valid3_q <= 1'b0;
            data3_q  <= '0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            msg_q    <= msg_d;
            mshr_q   <= mshr_d;
            plen_q   <= plen_d;
            line_q   <= line_d;
            chip_q   <= chip_d;
            x_q      <= x_d;
            y_q      <= y_d;
            flit_q   <= flit_d;
            word_q   <= word_d;
            wfull_q  <= wfull_d;
            lat_q    <= lat_d;
            ready_q  <= ready_d;
            valid3_q <= valid3_d;
            data3_q  <= data3_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        mshr_d   = mshr_q;
        plen_d   = plen_q;
        line_d   = line_q;
        chip_d   = chip_q;
        x_d      = x_q;
        y_d      = y_q;
        flit_d   = flit_q;
        word_d   = word_q;
        wfull_d  = wfull_q;
        lat_d    = lat_q;
        valid3_d = valid3_q;
        data3_d  = data3_q;
        err_d    = 1'b0;
        wr_en_c  = 1'b0;

        case (state_q)
            ST_RX_HDR: if (hs2_c) begin
                msg_d  = noc.noc2_data_in[MSG_TYPE_LSB +: MSG_TYPE_W];
                mshr_d = noc.noc2_data_in[MSHR_LSB +: MSHR_W];
                plen_d = noc.noc2_data_in[PLEN_LSB +: PLEN_W];
                flit_d = '0;
                if (!is_supported(noc.noc2_data_in[MSG_TYPE_LSB +: MSG_TYPE_W])) begin
                    err_d   = 1'b1;
                    state_d = (plen_d == '0) ? ST_RX_HDR : ST_DRAIN;
                end else begin
                    state_d = (plen_d == '0) ? ST_RX_HDR : ST_RX_ADDR;
                end
            end
            ST_RX_ADDR: if (hs2_c) begin
                line_d = noc.noc2_data_in[LINE_OFFSET_W +: LINE_W];
                flit_d = flit_q + 8'd1;
                if (last_flit_c) begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_W'(MEM_LAT - 1);
                end else begin
                    state_d = ST_RX_SRC;
                end
            end
            ST_RX_SRC: if (hs2_c) begin
                chip_d  = noc.noc2_data_in[CHIPID_LSB +: CHIPID_W];
                x_d     = noc.noc2_data_in[X_LSB +: X_W];
                y_d     = noc.noc2_data_in[Y_LSB +: Y_W];
                flit_d  = flit_q + 8'd1;
                word_d  = '0;
                wfull_d = 1'b0;
                if (last_flit_c || msg_q != MSG_STORE_MEM) begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_W'(MEM_LAT - 1);
                end else begin
                    state_d = ST_RX_DATA;
                end
            end
            // Words past the eighth are consumed but never written.
            ST_RX_DATA: if (hs2_c) begin
                wr_en_c = !wfull_q;
                word_d  = word_q + 3'd1;
                if (word_q == 3'd7) wfull_d = 1'b1;
                flit_d  = flit_q + 8'd1;
                if (last_flit_c) begin
                    state_d = ST_WAIT;
                    lat_d   = LAT_W'(MEM_LAT - 1);
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    state_d  = ST_TX_HDR;
                    valid3_d = 1'b1;
                    data3_d  = make_resp_hdr(chip_q, x_q, y_q, msg_q, mshr_q);
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_TX_HDR: if (hs3_c) begin
                if (msg_q == MSG_LOAD_MEM) begin
                    state_d = ST_TX_DATA;
                    word_d  = '0;
                    data3_d = rd_data_c;
                end else begin
                    state_d  = ST_RX_HDR;
                    valid3_d = 1'b0;
                    data3_d  = '0;
                end
            end
            ST_TX_DATA: if (hs3_c) begin
                if (word_q == 3'd7) begin
                    state_d  = ST_RX_HDR;
                    valid3_d = 1'b0;
                    data3_d  = '0;
                end else begin
                    word_d  = word_q + 3'd1;
                    data3_d = rd_data_c;
                end
            end
            ST_DRAIN: if (hs2_c) begin
                flit_d = flit_q + 8'd1;
                if (last_flit_c) state_d = ST_RX_HDR;
            end
            default: state_d = ST_RX_HDR;
        endcase

        ready_d = (state_d inside {ST_RX_HDR, ST_RX_ADDR, ST_RX_SRC, ST_RX_DATA, ST_DRAIN});
        busy_d  = (state_d != ST_RX_HDR);
    end

    assign noc.noc2_ready_out = ready_q;
    assign noc.noc3_valid_out = valid3_q;
    assign noc.noc3_data_out  = data3_q;
    assign busy               = busy_q;
    assign err_unsupported    = err_q;

endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: a table of load/store requests with
// hand-computed responses, plus backpressure, unsupported-type and reset sequences.
module tb_l2_mem_responder;

    localparam int MEM_LAT = 3;
    localparam logic [13:0] SRC_CHIP = 14'h15;

    typedef struct {
        logic             is_store;
        logic [7:0]       mshr;
        logic [39:0]      addr;
        logic [7:0]       x;
        logic [7:0]       y;
        logic [7:0]       plen;
        logic [9:0][63:0] wdata;
        logic [7:0][63:0] exp_words;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic busy;
    logic err_unsupported;

    l2_mem_responder_if noc ();

    l2_mem_responder #(.LINES(4), .MEM_LAT(MEM_LAT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .noc             (noc),
        .busy            (busy),
        .err_unsupported (err_unsupported)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] rx_q[$];
    int          rx_cyc[$];
    int          stall_cnt = 0;
    int          err_cnt   = 0;
    int          err_cyc   = -1;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endfunction

    // Response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("bp_hold_valid", 64'(noc.noc3_valid_out), 64'd1);
                check("bp_hold_data", noc.noc3_data_out, prev_data);
            end
            if (noc.noc3_valid_out && noc.noc3_ready_in) begin
                rx_q.push_back(noc.noc3_data_out);
                rx_cyc.push_back(cyc);
            end
            if (noc.noc3_valid_out && !noc.noc3_ready_in) stall_cnt++;
            if (err_unsupported) begin
                err_cnt++;
                err_cyc = cyc;
            end
            prev_stall = noc.noc3_valid_out && !noc.noc3_ready_in;
            prev_data  = noc.noc3_data_out;
        end
    end

    function automatic logic [63:0] req_hdr(input logic [7:0] typ, input logic [7:0] plen, input logic [7:0] mshr);
        return {14'h3, 8'h0, 8'h0, 4'hF, plen, typ, mshr, 6'h2A};
    endfunction

    function automatic logic [63:0] exp_hdr(input vec_t v);
        if (v.is_store) return {SRC_CHIP, v.x, v.y, 4'h0, 8'd0, 8'd25, v.mshr, 6'h0};
        return {SRC_CHIP, v.x, v.y, 4'h0, 8'd8, 8'd24, v.mshr, 6'h0};
    endfunction

    function automatic logic [9:0][63:0] ramp(input logic [63:0] base, input logic [63:0] step);
        logic [9:0][63:0] r;
        for (int i = 0; i < 10; i++) r[i] = base + step * 64'(i);
        return r;
    endfunction

    function automatic vec_t mk(input logic st, input logic [7:0] mshr, input logic [39:0] addr,
                                input logic [7:0] x, input logic [7:0] y, input logic [7:0] plen);
        vec_t v;
        v.is_store  = st;
        v.mshr      = mshr;
        v.addr      = addr;
        v.x         = x;
        v.y         = y;
        v.plen      = plen;
        v.wdata     = '0;
        v.exp_words = '0;
        return v;
    endfunction

    task automatic send(input logic [63:0] d, output int hc);
        noc.noc2_valid_in = 1'b1;
        noc.noc2_data_in  = d;
        hc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (noc.noc2_ready_out) hc = cyc;
            @(posedge clk);
            #1;
            if (hc >= 0) break;
        end
        noc.noc2_valid_in = 1'b0;
        noc.noc2_data_in  = '0;
        if (hc < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got no handshake, required handshake for flit 0x%0h", d);
        end
    endtask

    task automatic send_req(input vec_t v, output int last_hs);
        int hc;
        send(req_hdr(v.is_store ? 8'd20 : 8'd19, v.plen, v.mshr), hc);
        send({24'h0, v.addr}, hc);
        send({SRC_CHIP, v.x, v.y, 34'h0}, hc);
        for (int i = 0; i < int'(v.plen) - 2; i++) send(v.wdata[i], hc);
        last_hs = hc;
    endtask

    task automatic wait_rx(input int n);
        for (int k = 0; k < 300; k++) begin
            if (rx_q.size() >= n) break;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_resp(input vec_t v, input string tag, input int last_hs, input int span);
        int exp_n;
        exp_n = v.is_store ? 1 : 9;
        check({tag, "_flit_count"}, 64'(rx_q.size()), 64'(exp_n));
        if (rx_q.size() > 0) begin
            check({tag, "_hdr"}, rx_q[0], exp_hdr(v));
            check({tag, "_latency"}, 64'(rx_cyc[0]), 64'(last_hs + MEM_LAT + 1));
        end
        if (!v.is_store) begin
            for (int i = 0; i < 8; i++)
                if (i + 1 < rx_q.size()) check($sformatf("%s_word%0d", tag, i), rx_q[i+1], v.exp_words[i]);
        end
        if (rx_q.size() == exp_n)
            check({tag, "_span"}, 64'(rx_cyc[exp_n-1] - rx_cyc[0]), 64'(span));
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int hs;
        rx_q.delete();
        rx_cyc.delete();
        send_req(v, hs);
        wait_rx(v.is_store ? 1 : 9);
        check({tag, "_idle_after"}, {62'd0, noc.noc2_ready_out, busy}, 64'b10);
        repeat (3) begin @(posedge clk); #1; end
        check_resp(v, tag, hs, v.is_store ? 0 : 8);
    endtask

    vec_t             vecs [9];
    vec_t             rs_store, rs_load, ld_line1;
    logic [9:0][63:0] r;
    int               hs, hc, hdr_hs;
    logic             stalled;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1);
    end

    initial begin
        noc.noc2_valid_in = 1'b0;
        noc.noc2_data_in  = '0;
        noc.noc3_ready_in = 1'b1;

        // Request table with hand-computed responses (LINES = 4, line = addr[7:6]).
        vecs[0] = mk(1'b0, 8'd5, 40'h80, 8'd1, 8'd0, 8'd2);
        vecs[1] = mk(1'b1, 8'd6, 40'h40, 8'd2, 8'd3, 8'd10);
        r = ramp(64'h11, 64'h11);
        vecs[1].wdata = r;
        vecs[2] = mk(1'b0, 8'd7, 40'h40, 8'd2, 8'd3, 8'd2);
        vecs[2].exp_words = r[7:0];
        vecs[3] = mk(1'b1, 8'd8, 40'h12_3400_0058, 8'd4, 8'd5, 8'd4);
        vecs[3].wdata = ramp(64'hA1, 64'h1);
        vecs[4] = mk(1'b0, 8'd9, 40'h40, 8'd2, 8'd3, 8'd2);
        vecs[4].exp_words    = r[7:0];
        vecs[4].exp_words[0] = 64'hA1;
        vecs[4].exp_words[1] = 64'hA2;
        vecs[5] = mk(1'b1, 8'd10, 40'hC0, 8'd6, 8'd7, 8'd12);
        r = ramp(64'h301, 64'h1);
        vecs[5].wdata = r;
        vecs[6] = mk(1'b0, 8'd11, 40'hC0, 8'd6, 8'd7, 8'd2);
        vecs[6].exp_words = r[7:0];
        vecs[7] = mk(1'b0, 8'd12, 40'h100, 8'hFF, 8'hFE, 8'd2);
        vecs[8] = mk(1'b0, 8'hFF, 40'h80, 8'd1, 8'd0, 8'd2);

        rs_store = mk(1'b1, 8'd20, 40'h80, 8'd3, 8'd3, 8'd10);
        r = ramp(64'h201, 64'h1);
        rs_store.wdata = r;
        rs_load = mk(1'b0, 8'd21, 40'h80, 8'd3, 8'd3, 8'd2);
        rs_load.exp_words = r[7:0];

        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_ready", 64'(noc.noc2_ready_out), 64'd1);
        check("reset_valid", 64'(noc.noc3_valid_out), 64'd0);
        check("reset_data", noc.noc3_data_out, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_err", 64'(err_unsupported), 64'd0);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], $sformatf("v%0d", i));

        // Backpressure: drop ready for 3 cycles while word 4 (0x55) of line 1 is presented.
        rx_q.delete();
        rx_cyc.delete();
        stall_cnt = 0;
        stalled   = 1'b0;
        send_req(vecs[4], hs);
        for (int n = 0; n < 200; n++) begin
            if (rx_q.size() >= 9) break;
            if (!stalled && noc.noc3_valid_out && noc.noc3_data_out == 64'h55) begin
                noc.noc3_ready_in = 1'b0;
                repeat (3) begin @(posedge clk); #1; end
                noc.noc3_ready_in = 1'b1;
                stalled = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        repeat (3) begin @(posedge clk); #1; end
        check_resp(vecs[4], "bp", hs, 11);
        check("bp_stall_cycles", 64'(stall_cnt), 64'd3);

        // Unsupported type: drained flits look like LOAD_MEM headers and must not be parsed.
        rx_q.delete();
        rx_cyc.delete();
        err_cnt = 0;
        send(req_hdr(8'd1, 8'd3, 8'h9), hdr_hs);
        check("unsup_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 3; i++) send(req_hdr(8'd19, 8'd2, 8'h33), hc);
        repeat (12) begin @(posedge clk); #1; end
        check("unsup_err_count", 64'(err_cnt), 64'd1);
        check("unsup_err_cycle", 64'(err_cyc), 64'(hdr_hs + 1));
        check("unsup_no_noc3", 64'(rx_q.size()), 64'd0);
        check("unsup_idle", {62'd0, noc.noc2_ready_out, busy}, 64'b10);
        run_txn(vecs[6], "after_unsup");

        // Reset in the middle of a load response.
        run_txn(rs_store, "rs_store");
        rx_q.delete();
        rx_cyc.delete();
        send_req(rs_load, hs);
        for (int n = 0; n < 100; n++) begin
            if (noc.noc3_valid_out && noc.noc3_data_out == 64'h204) break;
            @(posedge clk);
            #1;
        end
        check("rs_word3_seen", noc.noc3_data_out, 64'h204);
        rst_n = 1'b0;
        #1;
        check("rs_valid_async", 64'(noc.noc3_valid_out), 64'd0);
        check("rs_data_async", noc.noc3_data_out, 64'd0);
        check("rs_ready_async", 64'(noc.noc2_ready_out), 64'd1);
        check("rs_busy_async", 64'(busy), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        rs_load.exp_words = '0;
        run_txn(rs_load, "rs_line2_zero");
        ld_line1 = vecs[4];
        ld_line1.exp_words = '0;
        run_txn(ld_line1, "rs_line1_zero");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
